// File: rtl/user_au_i2s_rx.sv
// I2S receiver: oversamples SCK on clk_i, deserializes MSB-first channel words
// into right-aligned 32-bit PCM samples, and buffers them in a small FIFO so
// downstream back-pressure does not lose samples.
module user_au_i2s_rx #(
    parameter int SampleWidth = 24,
    parameter int FifoDepth   = 4,
    parameter bit SignExtend  = 1'b1
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    input  logic                       enable_i,
    input  logic                       i2s_sck_i,
    input  logic                       i2s_ws_i,
    input  logic                       i2s_sd_i,
    output logic [31:0]                data_o,
    output logic                       channel_o,
    output logic                       valid_o,
    input  logic                       ready_i,
    output logic                       overflow_o,
    input  logic                       clear_overflow_i,
    output logic [$clog2(FifoDepth):0] fifo_level_o
);

    localparam int AddrW = $clog2(FifoDepth);
    localparam int CntW  = $clog2(SampleWidth + 1);
    localparam logic [AddrW:0]  LvlFull = (AddrW + 1)'(FifoDepth);
    localparam logic [CntW-1:0] CntMax  = CntW'(SampleWidth);

    typedef enum logic {S_IDLE, S_SHIFT} state_t;

    state_t                 r_state;
    logic                   r_sck_q;
    logic                   r_ws_prev;
    logic [CntW-1:0]        r_bit_cnt;
    logic [SampleWidth-1:0] r_word;

    logic [31:0]            r_mem_data [FifoDepth];
    logic                   r_mem_ch   [FifoDepth];
    logic [AddrW-1:0]       r_wr_ptr;
    logic [AddrW-1:0]       r_rd_ptr;
    logic [AddrW:0]         r_count;
    logic                   r_overflow;

    logic                   w_rise;
    logic                   w_ws_edge;
    logic                   w_bit_ok;
    logic                   w_push;
    logic [SampleWidth-1:0] w_word_next;
    logic [31:0]            w_push_data;
    logic                   w_empty;
    logic                   w_full;
    logic                   w_pop;
    logic                   w_wr;
    logic                   w_drop;

    // Widen a captured word to 32 bits, replicating its MSB when sign extension is on.
    function automatic logic [31:0] extend_word(input logic [SampleWidth-1:0] word);
        logic [31:0] res;
        res = {32{SignExtend & word[SampleWidth-1]}};
        res[SampleWidth-1:0] = word;
        return res;
    endfunction

    assign w_rise    = i2s_sck_i & ~r_sck_q;
    assign w_ws_edge = (i2s_ws_i != r_ws_prev);
    assign w_bit_ok  = (r_bit_cnt < CntMax);

    // Place the current SD bit at the next free position from the MSB down, so
    // short words come out left-justified and bits beyond SampleWidth are ignored.
    always_comb begin
        w_word_next = r_word;
        for (int i = 0; i < SampleWidth; i++) begin
            if (w_bit_ok && (int'(r_bit_cnt) == SampleWidth - 1 - i)) begin
                w_word_next[i] = i2s_sd_i;
            end
        end
    end

    // The SD bit on a WS-change rise is the LSB of the outgoing word, so the
    // pushed value already includes it.
    assign w_push      = enable_i && (r_state == S_SHIFT) && w_rise && w_ws_edge;
    assign w_push_data = extend_word(w_word_next);

    // Deserializer FSM: IDLE waits for a word boundary, SHIFT accumulates bits.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state   <= S_IDLE;
            r_sck_q   <= 1'b0;
            r_ws_prev <= 1'b0;
            r_bit_cnt <= '0;
        end else begin
            r_sck_q <= i2s_sck_i;
            // WS history is tracked even while disabled so that re-enabling
            // mid-frame waits for a genuine boundary.
            if (w_rise) begin
                r_ws_prev <= i2s_ws_i;
            end
            if (!enable_i) begin
                r_state   <= S_IDLE;
                r_bit_cnt <= '0;
            end else if (w_rise) begin
                case (r_state)
                    S_IDLE: begin
                        if (w_ws_edge) begin
                            r_state   <= S_SHIFT;
                            r_bit_cnt <= '0;
                            r_word    <= '0;
                        end
                    end
                    S_SHIFT: begin
                        if (w_ws_edge) begin
                            r_bit_cnt <= '0;
                            r_word    <= '0;
                        end else begin
                            r_word <= w_word_next;
                            if (w_bit_ok) begin
                                r_bit_cnt <= r_bit_cnt + CntW'(1);
                            end
                        end
                    end
                    default: r_state <= S_IDLE;
                endcase
            end
        end
    end

    assign w_empty = (r_count == '0);
    assign w_full  = (r_count == LvlFull);
    assign w_pop   = !w_empty && ready_i;
    // A push into a full FIFO still lands when the head leaves in the same cycle.
    assign w_wr    = w_push && (!w_full || w_pop);
    assign w_drop  = w_push && w_full && !w_pop;

    // FIFO pointers, occupancy and sticky overflow flag.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_overflow <= 1'b0;
        end else begin
            if (w_wr) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_wr, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
            if (w_drop) begin
                r_overflow <= 1'b1;
            end else if (clear_overflow_i) begin
                r_overflow <= 1'b0;
            end
        end
    end

    // FIFO storage; contents need no reset because the outputs are gated by occupancy.
    always_ff @(posedge clk_i) begin
        if (w_wr) begin
            r_mem_data[r_wr_ptr] <= w_push_data;
            r_mem_ch[r_wr_ptr]   <= r_ws_prev;
        end
    end

    assign valid_o      = !w_empty;
    assign data_o       = w_empty ? 32'd0 : r_mem_data[r_rd_ptr];
    assign channel_o    = w_empty ? 1'b0 : r_mem_ch[r_rd_ptr];
    assign overflow_o   = r_overflow;
    assign fifo_level_o = r_count;

endmodule

// File: tb/tb_user_au_i2s_rx.sv
// Directed bench for user_au_i2s_rx: drives I2S frames at SCK = clk/8 and
// checks popped samples against a queue of hand-computed expected values.
module tb_user_au_i2s_rx;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        enable_i;
    logic        i2s_sck_i;
    logic        i2s_ws_i;
    logic        i2s_sd_i;
    logic [31:0] data_o;
    logic        channel_o;
    logic        valid_o;
    logic        ready_i;
    logic        overflow_o;
    logic        clear_overflow_i;
    logic [2:0]  fifo_level_o;

    int          n_total = 0;
    int          n_bad   = 0;
    logic        pend    = 1'b0;
    logic        cur_ws  = 1'b0;
    logic [32:0] exp_q[$];

    always #5 clk_i = ~clk_i;

    user_au_i2s_rx #(
        .SampleWidth(24),
        .FifoDepth  (4),
        .SignExtend (1'b1)
    ) dut (
        .clk_i           (clk_i),
        .rst_i           (rst_i),
        .enable_i        (enable_i),
        .i2s_sck_i       (i2s_sck_i),
        .i2s_ws_i        (i2s_ws_i),
        .i2s_sd_i        (i2s_sd_i),
        .data_o          (data_o),
        .channel_o       (channel_o),
        .valid_o         (valid_o),
        .ready_i         (ready_i),
        .overflow_o      (overflow_o),
        .clear_overflow_i(clear_overflow_i),
        .fifo_level_o    (fifo_level_o)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk_i);
        #1;
    endtask

    // One SCK period: 4 clocks low with WS/SD set up, then 4 clocks high.
    // mode 1: valid_o must be low in the rise cycle and high one cycle later.
    // mode 2: ready_i is pulsed for exactly the rise cycle.
    task automatic rise(input logic ws, input logic sd, input int mode);
        i2s_ws_i = ws;
        i2s_sd_i = sd;
        tick(4);
        i2s_sck_i = 1'b1;
        if (mode == 2) ready_i = 1'b1;
        if (mode == 1) chk("valid_before_push", 64'(valid_o), 64'd0);
        tick(1);
        if (mode == 1) chk("valid_after_push", 64'(valid_o), 64'd1);
        if (mode == 2) ready_i = 1'b0;
        tick(3);
        i2s_sck_i = 1'b0;
        cur_ws = ws;
    endtask

    // Remaining bits of the word already started by a boundary rise; the LSB is
    // held back for the next boundary.
    task automatic cont_word(input logic [31:0] val, input int n);
        for (int i = n - 1; i >= 1; i--) rise(cur_ws, val[i], 0);
        pend = val[0];
    endtask

    task automatic send_word(input logic ch, input logic [31:0] val, input int n, input int mode);
        rise(ch, pend, mode);
        cont_word(val, n);
    endtask

    // Consumer-side scoreboard: every accepted sample must match the queue head.
    always @(negedge clk_i) begin
        logic [32:0] e;
        if (!rst_i && valid_o && ready_i) begin
            if (exp_q.size() == 0) begin
                chk("pop_unexpected", {31'd0, channel_o, data_o}, 64'hFFFF_FFFF_FFFF_FFFF);
            end else begin
                e = exp_q.pop_front();
                chk("pop_sample", {31'd0, channel_o, data_o}, 64'(e));
            end
        end
    end

    initial begin
        rst_i = 1'b1; enable_i = 1'b0; ready_i = 1'b0; clear_overflow_i = 1'b0;
        i2s_sck_i = 1'b0; i2s_ws_i = 1'b0; i2s_sd_i = 1'b0;
        tick(3);
        chk("rst_valid", 64'(valid_o), 64'd0);
        chk("rst_data", 64'(data_o), 64'd0);
        chk("rst_channel", 64'(channel_o), 64'd0);
        chk("rst_overflow", 64'(overflow_o), 64'd0);
        chk("rst_level", 64'(fifo_level_o), 64'd0);
        rst_i = 1'b0; enable_i = 1'b1; ready_i = 1'b1;

        // Basic stereo: first WS edge opens a word; each later boundary emits one.
        send_word(1'b1, 32'h00ABCDEF, 24, 0);
        exp_q.push_back({1'b1, 32'hFFABCDEF});
        send_word(1'b0, 32'h00123456, 24, 1);
        exp_q.push_back({1'b0, 32'h00123456});
        send_word(1'b1, 32'h00FEDCBA, 24, 1);
        exp_q.push_back({1'b1, 32'hFFFEDCBA});

        // Long (32-bit) and short (16-bit) frames, then WS glitches of one bit.
        send_word(1'b0, 32'h80000001, 32, 1);
        exp_q.push_back({1'b0, 32'hFF800000});
        send_word(1'b1, 32'h00007FFF, 16, 1);
        exp_q.push_back({1'b1, 32'h007FFF00});
        rise(1'b0, pend, 1);
        exp_q.push_back({1'b0, 32'hFF800000});
        rise(1'b1, 1'b1, 1);
        exp_q.push_back({1'b1, 32'h00000000});
        rise(1'b0, 1'b0, 1);
        pend = 1'b0;
        tick(4);
        chk("basic_drained", 64'(exp_q.size()), 64'd0);

        // Back-pressure: six words into a four-deep FIFO.
        ready_i = 1'b0;
        exp_q.push_back({1'b0, 32'h00000001});
        exp_q.push_back({1'b1, 32'hFF800000});
        exp_q.push_back({1'b0, 32'h007FFFFF});
        exp_q.push_back({1'b1, 32'h000F0F0F});
        cont_word(32'h00000001, 24);
        send_word(1'b1, 32'h00800000, 24, 0);
        send_word(1'b0, 32'h007FFFFF, 24, 0);
        send_word(1'b1, 32'h000F0F0F, 24, 0);
        send_word(1'b0, 32'h00111111, 24, 0);
        send_word(1'b1, 32'h00222222, 24, 0);
        rise(1'b0, pend, 0);
        chk("bp_level_full", 64'(fifo_level_o), 64'd4);
        chk("bp_overflow", 64'(overflow_o), 64'd1);
        chk("bp_valid", 64'(valid_o), 64'd1);
        chk("bp_head", {31'd0, channel_o, data_o}, {31'd0, 1'b0, 32'h00000001});
        tick(2);
        chk("bp_head_stable", 64'(data_o), 64'h00000001);
        ready_i = 1'b1;
        tick(10);
        chk("bp_level_empty", 64'(fifo_level_o), 64'd0);
        chk("bp_drained", 64'(exp_q.size()), 64'd0);
        chk("bp_overflow_held", 64'(overflow_o), 64'd1);
        clear_overflow_i = 1'b1;
        tick(1);
        clear_overflow_i = 1'b0;
        chk("bp_overflow_cleared", 64'(overflow_o), 64'd0);

        // Full FIFO with push and pop in the same cycle.
        ready_i = 1'b0;
        exp_q.push_back({1'b0, 32'h00000010});
        exp_q.push_back({1'b1, 32'h00000020});
        exp_q.push_back({1'b0, 32'h00000030});
        exp_q.push_back({1'b1, 32'h00000040});
        exp_q.push_back({1'b0, 32'h00000050});
        cont_word(32'h00000010, 24);
        send_word(1'b1, 32'h00000020, 24, 0);
        send_word(1'b0, 32'h00000030, 24, 0);
        send_word(1'b1, 32'h00000040, 24, 0);
        send_word(1'b0, 32'h00000050, 24, 0);
        chk("pp_level_before", 64'(fifo_level_o), 64'd4);
        rise(1'b1, pend, 2);
        chk("pp_level_after", 64'(fifo_level_o), 64'd4);
        chk("pp_overflow", 64'(overflow_o), 64'd0);
        chk("pp_head", {31'd0, channel_o, data_o}, {31'd0, 1'b1, 32'h00000020});
        ready_i = 1'b1;
        tick(10);
        chk("pp_drained", 64'(exp_q.size()), 64'd0);
        chk("pp_level_empty", 64'(fifo_level_o), 64'd0);

        // Enable dropped mid-word; neither that word nor the next partial appears.
        exp_q.push_back({1'b1, 32'h00000000});
        rise(1'b0, 1'b0, 1);
        for (int i = 0; i < 10; i++) rise(1'b0, 1'b1, 0);
        enable_i = 1'b0;
        for (int i = 0; i < 13; i++) rise(1'b0, 1'b1, 0);
        rise(1'b1, 1'b1, 0);
        for (int i = 0; i < 5; i++) rise(1'b1, 1'b0, 0);
        enable_i = 1'b1;
        for (int i = 0; i < 18; i++) rise(1'b1, 1'b0, 0);
        pend = 1'b0;
        send_word(1'b0, 32'h00345678, 24, 0);
        chk("en_no_partial", 64'(valid_o), 64'd0);
        exp_q.push_back({1'b0, 32'h00345678});
        rise(1'b1, pend, 1);
        tick(4);
        chk("en_drained", 64'(exp_q.size()), 64'd0);

        // Reset with a sample buffered and a word in progress.
        ready_i = 1'b0;
        for (int i = 0; i < 23; i++) rise(1'b1, 1'b0, 0);
        rise(1'b0, 1'b0, 1);
        for (int i = 0; i < 10; i++) rise(1'b0, 1'b1, 0);
        chk("rst_mid_level_before", 64'(fifo_level_o), 64'd1);
        rst_i = 1'b1;
        tick(1);
        chk("rst_mid_valid", 64'(valid_o), 64'd0);
        chk("rst_mid_level", 64'(fifo_level_o), 64'd0);
        rst_i = 1'b0;
        exp_q.delete();

        // Enable mid-frame: WS changes while disabled must not start a word.
        ready_i = 1'b1;
        enable_i = 1'b0;
        for (int i = 0; i < 5; i++) rise(1'b0, 1'b1, 0);
        for (int i = 0; i < 6; i++) rise(1'b1, 1'b1, 0);
        enable_i = 1'b1;
        for (int i = 0; i < 5; i++) rise(1'b1, 1'b0, 0);
        pend = 1'b1;
        send_word(1'b0, 32'h00654321, 24, 0);
        chk("first_word_no_emit", 64'(valid_o), 64'd0);
        exp_q.push_back({1'b0, 32'h00654321});
        send_word(1'b1, 32'h00800001, 24, 1);
        exp_q.push_back({1'b1, 32'hFF800001});
        rise(1'b0, pend, 1);
        tick(4);
        chk("first_word_drained", 64'(exp_q.size()), 64'd0);
        chk("final_level", 64'(fifo_level_o), 64'd0);
        chk("final_overflow", 64'(overflow_o), 64'd0);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
